// File: rtl/clock_time_pkg.sv
// Shared types and field moduli for the digital clock timekeeping slice.
package clock_time_pkg;

  typedef enum logic [1:0] {
    ModeRun    = 2'd0,
    ModeSetHr  = 2'd1,
    ModeSetMin = 2'd2,
    ModeSetSec = 2'd3
  } mode_t;

  typedef logic [3:0] bcd_t;

  localparam int unsigned SEC_MOD   = 60;
  localparam int unsigned MIN_MOD   = 60;
  localparam int unsigned HR_MOD_24 = 24;
  localparam int unsigned HR_MOD_12 = 12;

  function automatic logic bcd_digit_ok(input bcd_t d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_pair_cnt.sv
// Two-digit BCD modulo counter. TWELVE_HR selects the 1..MOD sequence with reset to MOD;
// otherwise it counts 0..MOD-1. wrap_out flags an increment while sitting at MOD-1.
module bcd_pair_cnt
  import clock_time_pkg::*;
#(
  parameter int unsigned MOD       = 60,
  parameter bit          TWELVE_HR = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic       wrap_out,
  output logic [3:0] lo,
  output logic [3:0] hi
);

  localparam int unsigned MaxVal = TWELVE_HR ? MOD : MOD - 1;
  localparam int unsigned MinVal = TWELVE_HR ? 1 : 0;
  localparam int unsigned RstVal = TWELVE_HR ? MOD : 0;

  localparam bcd_t MaxHi  = bcd_t'(MaxVal / 10);
  localparam bcd_t MaxLo  = bcd_t'(MaxVal % 10);
  localparam bcd_t MinHi  = bcd_t'(MinVal / 10);
  localparam bcd_t MinLo  = bcd_t'(MinVal % 10);
  localparam bcd_t RstHi  = bcd_t'(RstVal / 10);
  localparam bcd_t RstLo  = bcd_t'(RstVal % 10);
  localparam bcd_t WrapHi = bcd_t'((MOD - 1) / 10);
  localparam bcd_t WrapLo = bcd_t'((MOD - 1) % 10);

  bcd_t lo_q, lo_d;
  bcd_t hi_q, hi_d;
  logic legal, at_max, at_wrap;

  // Out-of-range contents (upset) are not walked forward; the next update reloads the base.
  assign legal   = bcd_digit_ok(lo_q) &&
                   ((hi_q < MaxHi) || ((hi_q == MaxHi) && (lo_q <= MaxLo))) &&
                   !(TWELVE_HR && (hi_q == 4'd0) && (lo_q == 4'd0));
  assign at_max   = (hi_q == MaxHi) && (lo_q == MaxLo);
  assign at_wrap  = (hi_q == WrapHi) && (lo_q == WrapLo);
  assign wrap_out = inc && at_wrap;

  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    if (clr || (inc && !legal)) begin
      hi_d = RstHi;
      lo_d = RstLo;
    end else if (inc) begin
      if (at_max) begin
        hi_d = MinHi;
        lo_d = MinLo;
      end else if (lo_q == 4'd9) begin
        hi_d = hi_q + 4'd1;
        lo_d = 4'd0;
      end else begin
        lo_d = lo_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q <= RstLo;
      hi_q <= RstHi;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign lo = lo_q;
  assign hi = hi_q;

endmodule

// File: rtl/clock_time_ctrl.sv
// Clock timekeeping and time-setting controller: 1 Hz prescaler, set-mode FSM, blink divider
// and the sec/min/hr BCD chain. Define CLOCK_TIME_CTRL_12H_EN for 12-hour mode with a pm output.
module clock_time_ctrl
  import clock_time_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned BLINK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min_lo,
  output logic [3:0] min_hi,
  output logic [3:0] hr_lo,
  output logic [3:0] hr_hi,
  output logic [1:0] mode,
  output logic       blink,
  output logic       sec_tick
`ifdef CLOCK_TIME_CTRL_12H_EN
  ,
  output logic       pm
`endif
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] TickMax  = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BlinkMax = BW'(BLINK_DIV - 1);

`ifdef CLOCK_TIME_CTRL_12H_EN
  localparam int unsigned HrMod  = HR_MOD_12;
  localparam bit          HrTwelve = 1'b1;
`else
  localparam int unsigned HrMod  = HR_MOD_24;
  localparam bit          HrTwelve = 1'b0;
`endif

  mode_t         mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] bdiv_q, bdiv_d;
  logic          blink_q, blink_d;
  logic          tick_q;

  logic run, tick, edit_inc;
  logic sec_inc, sec_clr, min_inc, hr_inc;
  logic sec_wrap, min_wrap, hr_wrap;

  assign run      = (mode_q == ModeRun);
  assign tick     = run && (presc_q == TickMax);
  // mode_btn takes priority, so a coincident inc_btn is dropped.
  assign edit_inc = inc_btn && !mode_btn && !run;

  always_comb begin
    mode_d = mode_q;
    if (mode_btn) begin
      unique case (mode_q)
        ModeRun:    mode_d = ModeSetHr;
        ModeSetHr:  mode_d = ModeSetMin;
        ModeSetMin: mode_d = ModeSetSec;
        ModeSetSec: mode_d = ModeRun;
      endcase
    end
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    if (!run || mode_btn || tick) begin
      presc_d = '0;
    end
  end

  always_comb begin
    bdiv_d  = bdiv_q + BW'(1);
    blink_d = blink_q;
    if (run || mode_btn || edit_inc) begin
      bdiv_d  = '0;
      blink_d = 1'b0;
    end else if (bdiv_q == BlinkMax) begin
      bdiv_d  = '0;
      blink_d = !blink_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= ModeRun;
      presc_q <= '0;
      bdiv_q  <= '0;
      blink_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      presc_q <= presc_d;
      bdiv_q  <= bdiv_d;
      blink_q <= blink_d;
      tick_q  <= tick;
    end
  end

  // Set-mode increments of minutes must not carry into hours, hence the run qualifier.
  assign sec_inc = tick;
  assign sec_clr = edit_inc && (mode_q == ModeSetSec);
  assign min_inc = sec_wrap || (edit_inc && (mode_q == ModeSetMin));
  assign hr_inc  = (run && min_wrap) || (edit_inc && (mode_q == ModeSetHr));

  bcd_pair_cnt #(
    .MOD       (SEC_MOD),
    .TWELVE_HR (1'b0)
  ) u_sec (
    .clk      (clk),
    .rst      (rst),
    .inc      (sec_inc),
    .clr      (sec_clr),
    .wrap_out (sec_wrap),
    .lo       (sec_lo),
    .hi       (sec_hi)
  );

  bcd_pair_cnt #(
    .MOD       (MIN_MOD),
    .TWELVE_HR (1'b0)
  ) u_min (
    .clk      (clk),
    .rst      (rst),
    .inc      (min_inc),
    .clr      (1'b0),
    .wrap_out (min_wrap),
    .lo       (min_lo),
    .hi       (min_hi)
  );

  bcd_pair_cnt #(
    .MOD       (HrMod),
    .TWELVE_HR (HrTwelve)
  ) u_hr (
    .clk      (clk),
    .rst      (rst),
    .inc      (hr_inc),
    .clr      (1'b0),
    .wrap_out (hr_wrap),
    .lo       (hr_lo),
    .hi       (hr_hi)
  );

`ifdef CLOCK_TIME_CTRL_12H_EN
  logic pm_q;

  // The hour counter wraps on 11->12, which is exactly where AM/PM flips.
  always_ff @(posedge clk) begin
    if (rst) begin
      pm_q <= 1'b0;
    end else if (hr_wrap) begin
      pm_q <= !pm_q;
    end
  end

  assign pm = pm_q;
`else
  logic unused_hr_wrap;
  assign unused_hr_wrap = hr_wrap;
`endif

  assign mode     = mode_q;
  assign blink    = blink_q;
  assign sec_tick = tick_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed self-checking bench for clock_time_ctrl with TICK_DIV=4, BLINK_DIV=2.
module tb_clock_time_ctrl;

  localparam int unsigned TickDiv  = 4;
  localparam int unsigned BlinkDiv = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode_btn;
  logic       inc_btn;
  logic [3:0] sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi;
  logic [1:0] mode;
  logic       blink;
  logic       sec_tick;
`ifdef CLOCK_TIME_CTRL_12H_EN
  logic       pm;
`endif

  logic [23:0] t_now;
  assign t_now = {hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo};

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  clock_time_ctrl #(
    .TICK_DIV  (TickDiv),
    .BLINK_DIV (BlinkDiv)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode_btn (mode_btn),
    .inc_btn  (inc_btn),
    .sec_lo   (sec_lo),
    .sec_hi   (sec_hi),
    .min_lo   (min_lo),
    .min_hi   (min_hi),
    .hr_lo    (hr_lo),
    .hr_hi    (hr_hi),
    .mode     (mode),
    .blink    (blink),
    .sec_tick (sec_tick)
`ifdef CLOCK_TIME_CTRL_12H_EN
    ,
    .pm       (pm)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_mode();
    mode_btn = 1'b1;
    @(negedge clk);
    mode_btn = 1'b0;
  endtask

  task automatic pulse_inc(input int n);
    inc_btn = 1'b1;
    repeat (n) @(negedge clk);
    inc_btn = 1'b0;
  endtask

  int ticks, first_tick, last_tick, bad_gap;

  initial begin
    rst      = 1'b1;
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    cyc(2);

`ifndef CLOCK_TIME_CTRL_12H_EN
    check("rst_time", t_now, 24'h000000);
    check("rst_mode", mode, 2'd0);
    check("rst_blink", blink, 1'b0);
    check("rst_tick", sec_tick, 1'b0);
    rst = 1'b0;

    // Free run for 240 cycles: ticks at cycles 4, 8, ... 240.
    ticks = 0; first_tick = 0; last_tick = 0; bad_gap = 0;
    for (int i = 1; i <= 240; i++) begin
      @(negedge clk);
      if (sec_tick) begin
        ticks++;
        if (first_tick == 0) first_tick = i;
        if (last_tick != 0 && (i - last_tick) != 4) bad_gap++;
        last_tick = i;
      end
    end
    check("run_tick_count", ticks, 60);
    check("run_first_tick", first_tick, 4);
    check("run_last_tick", last_tick, 240);
    check("run_tick_period", bad_gap, 0);
    check("run_time_1min", t_now, 24'h000100);
    check("run_blink", blink, 1'b0);
    check("run_mode", mode, 2'd0);

    // Set hours.
    pulse_mode();
    check("enter_set_hr", mode, 2'd1);
    check("set_hr_blink0", blink, 1'b0);
    pulse_inc(23);
    check("set_hr_23", t_now, 24'h230100);
    pulse_inc(1);
    check("set_hr_wrap", t_now, 24'h000100);
    pulse_inc(23);
    check("set_hr_23b", t_now, 24'h230100);

    // Set minutes, including 59 -> 00 without carry.
    pulse_mode();
    check("enter_set_min", mode, 2'd2);
    pulse_inc(58);
    check("set_min_59", t_now, 24'h235900);
    pulse_inc(1);
    check("set_min_wrap_nocarry", t_now, 24'h230000);
    pulse_inc(59);
    check("set_min_59b", t_now, 24'h235900);

    pulse_mode();
    pulse_mode();
    check("back_to_run", mode, 2'd0);
    cyc(3);
    check("reentry_no_early_tick", sec_tick, 1'b0);
    cyc(1);
    check("reentry_tick_at_4", sec_tick, 1'b1);
    check("reentry_time", t_now, 24'h235901);
    cyc(228);
    check("preload_235958", t_now, 24'h235958);
    cyc(4);
    check("time_235959", t_now, 24'h235959);
    check("tick_235959", sec_tick, 1'b1);
    cyc(3);
    check("hold_235959", t_now, 24'h235959);
    cyc(1);
    check("midnight_rollover", t_now, 24'h000000);
    check("midnight_tick", sec_tick, 1'b1);

    // Seconds clear and blink cadence in SET_SEC.
    cyc(12);
    check("run_000003", t_now, 24'h000003);
    pulse_mode();
    pulse_mode();
    pulse_mode();
    check("enter_set_sec", mode, 2'd3);
    check("set_sec_blink_a", blink, 1'b0);
    cyc(1);
    check("set_sec_blink_b", blink, 1'b0);
    cyc(1);
    check("set_sec_blink_toggle", blink, 1'b1);
    check("set_sec_no_tick_time", t_now, 24'h000003);
    pulse_inc(1);
    check("set_sec_clear", t_now, 24'h000000);
    check("inc_forces_blink0", blink, 1'b0);
    cyc(1);
    check("inc_blink_restart_a", blink, 1'b0);
    cyc(1);
    check("inc_blink_restart_b", blink, 1'b1);

    // mode_btn beats a coincident inc_btn.
    pulse_mode();
    check("sec_to_run", mode, 2'd0);
    pulse_mode();
    pulse_inc(5);
    check("set_hr_05", t_now, 24'h050000);
    mode_btn = 1'b1;
    inc_btn  = 1'b1;
    @(negedge clk);
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    check("both_btn_mode", mode, 2'd2);
    check("both_btn_hr_kept", t_now, 24'h050000);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sec_tick) ticks++;
    end
    check("no_tick_in_set", ticks, 0);
    check("no_tick_time", t_now, 24'h050000);

    // Build 12:34:56, then reset in the middle of SET_MIN.
    pulse_inc(34);
    check("set_min_34", t_now, 24'h053400);
    pulse_mode();
    pulse_mode();
    pulse_mode();
    pulse_inc(7);
    check("set_hr_12", t_now, 24'h123400);
    pulse_mode();
    pulse_mode();
    pulse_mode();
    check("run_again", mode, 2'd0);
    cyc(224);
    check("time_123456", t_now, 24'h123456);
    pulse_mode();
    pulse_mode();
    check("mid_edit_mode", mode, 2'd2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("rst_mid_edit_time", t_now, 24'h000000);
    check("rst_mid_edit_mode", mode, 2'd0);
    check("rst_mid_edit_blink", blink, 1'b0);
    check("rst_mid_edit_tick", sec_tick, 1'b0);
    cyc(3);
    check("post_rst_no_early_tick", sec_tick, 1'b0);
    cyc(1);
    check("post_rst_tick_at_4", sec_tick, 1'b1);
    check("post_rst_time", t_now, 24'h000001);
`else
    check("rst12_time", t_now, 24'h120000);
    check("rst12_pm", pm, 1'b0);
    check("rst12_mode", mode, 2'd0);
    rst = 1'b0;
    pulse_mode();
    pulse_inc(1);
    check("set12_hr_01", t_now, 24'h010000);
    check("set12_pm_am", pm, 1'b0);
    pulse_inc(10);
    check("set12_hr_11", t_now, 24'h110000);
    pulse_mode();
    pulse_inc(59);
    check("set12_min_59", t_now, 24'h115900);
    pulse_mode();
    pulse_mode();
    check("run12_mode", mode, 2'd0);
    cyc(236);
    check("run12_115959", t_now, 24'h115959);
    check("run12_still_am", pm, 1'b0);
    cyc(4);
    check("run12_noon", t_now, 24'h120000);
    check("run12_pm", pm, 1'b1);
    check("run12_tick", sec_tick, 1'b1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("rst12b_time", t_now, 24'h120000);
    check("rst12b_pm", pm, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
